lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store control stage between the MEM pipeline stage and the byte-enabled data memory array.
- Accepts one load/store request per handshake and checks alignment, funct3 legality and address range.
- Builds word-aligned address, per-byte write enables and lane-replicated write data; drives a single synchronous memory port.
- Extracts and sign/zero-extends load data and returns one response pulse per request.
- Replaces the combinational funct3 decode currently done at the memory boundary with a registered, handshaked stage.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory; valid addresses are 0 .. 2^DM_ADDRESS-1.
- DATA_W, 32, data word width; fixed at 32, 4 byte lanes.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  lsu can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instr[14:12].
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_misaligned  out  1  alignment fault, qualified by resp_valid.
- resp_illegal  out  1  bad funct3 or out-of-range address, qualified by resp_valid.
- mem_addr  out  DM_ADDRESS  word-aligned address, [1:0] always 0.
- mem_re  out  1  read strobe.
- mem_we  out  4  per-byte write enable.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  word read; valid the cycle after mem_re.

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=0 while rst_n low, 1 on the first cycle after release; all other outputs 0.
- Reset mid-operation aborts the access. No mem_we or resp_valid is produced for the aborted request.
- Request is captured into registers when req_valid && req_ready (cycle T).
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
  - IDLE -> ISSUE on accept of a legal request.
  - IDLE -> RESP on accept of a faulting request.
  - ISSUE -> RD_WAIT for a load.
  - ISSUE -> RESP for a store.
  - RD_WAIT -> RESP.
  - RESP -> IDLE.
- Faults are checked on the captured request at the accept cycle. A fault never touches memory.
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores 011 and any 1xx.
  - Out of range: addr[31:DM_ADDRESS] != 0. Reported as resp_illegal.
  - Illegal takes priority over misaligned; only one flag is set.
- Latency, from accept at T:
  - Load: mem_re=1 at T+1, mem_rdata captured at T+2, resp_valid at T+3.
  - Store: mem_we at T+1, resp_valid at T+2.
  - Fault: resp_valid at T+1.
- Memory-side outputs are active only in ISSUE; mem_re/mem_we are 0 in every other state.
- Byte enables, with o = addr[1:0]:
  - SB: 4'b0001<<o.
  - SH: 4'b0011<<o.
  - SW: 4'b1111.
- Write data: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
- Load extract: s = mem_rdata >> (8*o), then:
  - LB sext(s[7:0]); LBU zext(s[7:0]).
  - LH sext(s[15:0]); LHU zext(s[15:0]).
  - LW mem_rdata.
- resp_rdata is registered and held only during the RESP cycle, 0 otherwise.
- req_ready is low from T+1 until the RESP cycle inclusive. The next accept can occur in the cycle after RESP, giving a back-to-back throughput of one request per 4 cycles (load) or 3 cycles (store).
- Highest byte address 2^DM_ADDRESS-1 is in range. 2^DM_ADDRESS is illegal (no wrap).

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum.
  - lsu_req_t struct {we, funct3, addr, wdata}.
- One combinational sub-module, lsu_align: byte-enable/write-replication and load-extract functions, reused by the bench as a reference model.

Test Plan:
- SW 0xDEADBEEF to 0x010 -> at T+1 mem_addr=0x010, mem_we=1111, mem_wdata=0xDEADBEEF; resp_valid at T+2, both flags 0.
- SB 0x000000A5 to 0x013 -> mem_we=1000, mem_wdata=0xA5A5A5A5. Then LB 0x013 with mem_rdata=0xA5000000 -> resp_rdata=0xFFFFFFA5 at T+3; LBU gives 0x000000A5.
- SH 0x8001 to 0x012 -> mem_we=1100, mem_wdata=0x80018001. LH 0x012 with mem_rdata=0x80010000 -> resp_rdata=0xFFFF8001.
- Faults:
  - LW 0x006 -> resp_misaligned=1 at T+1, mem_re never asserted.
  - SH 0x001 -> resp_misaligned=1.
  - LW 0x200 (DM_ADDRESS=9) -> resp_illegal=1.
  - Store with funct3=100 -> resp_illegal=1.
- Back-to-back load/load/store with req_valid held high -> req_ready pulses at 4-cycle then 4-cycle spacing; three resp_valid pulses in order with correct data.
- rst_n pulled low at the ISSUE cycle of a store -> mem_we=0 immediately. After release: no resp_valid, req_ready=1, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store control stage.
//   - funct3 encodings for load/store access size and signedness
//   - lsu_state_t: control FSM states
//   - lsu_req_t: captured request (direction, funct3, byte address, store data)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane helpers for the load/store stage.
// Ports:
//   i_funct3  access size/sign (instr[14:12])
//   i_offset  byte offset within the word (addr[1:0])
//   i_wdata   raw store data (rs2)
//   i_rdata   raw word read from memory
//   o_be      per-byte write enables
//   o_wdata   store data replicated across the byte lanes
//   o_rdata   load data shifted down and sign/zero-extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_offset,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // funct3[1:0] carries the access size; funct3[2] only selects zero-extension.
  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   f_be = 4'b0001 << off;
      2'b01:   f_be = 4'b0011 << off;
      default: f_be = 4'b1111;
    endcase
  endfunction

  // Replicating into every lane lets the memory pick the byte with o_be alone.
  function automatic logic [DATA_W-1:0] f_wdata(input logic [2:0] f3,
                                                input logic [DATA_W-1:0] wd);
    case (f3[1:0])
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [DATA_W-1:0] rd);
    logic signed [DATA_W-1:0] s;
    s = rd >> {off, 3'b000};
    case (f3)
      F3_B:    f_extract = {{(DATA_W-8){s[7]}}, s[7:0]};
      F3_BU:   f_extract = {{(DATA_W-8){1'b0}}, s[7:0]};
      F3_H:    f_extract = {{(DATA_W-16){s[15]}}, s[15:0]};
      F3_HU:   f_extract = {{(DATA_W-16){1'b0}}, s[15:0]};
      default: f_extract = rd;
    endcase
  endfunction

  assign o_be    = f_be(i_funct3, i_offset);
  assign o_wdata = f_wdata(i_funct3, i_wdata);
  assign o_rdata = f_extract(i_funct3, i_offset, i_rdata);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: registered load/store control stage between MEM and the data memory.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we, req_funct3,
//   req_addr, req_wdata          request: direction, funct3, byte address, store data
//   resp_valid                   one-cycle response pulse
//   resp_rdata                   extended load data (0 for stores and faults)
//   resp_misaligned/resp_illegal fault flags, qualified by resp_valid
//   mem_addr, mem_re, mem_we,
//   mem_wdata, mem_rdata         synchronous byte-enabled memory port
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t        r_state, w_next;
  lsu_req_t          r_req;
  logic              r_mis, r_ill;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept, w_bad_f3, w_oor, w_ill, w_mis_raw, w_mis, w_fault;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep, w_ext;
  logic              w_unused_addr;

  // Gating with rst_n keeps ready low for the whole time reset is held.
  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // Fault decode on the live request so the verdict is latched with the accept.
  assign w_bad_f3  = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign w_oor     = |req_addr[31:DM_ADDRESS];
  assign w_ill     = w_bad_f3 || w_oor;
  assign w_mis_raw = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  // Illegal wins so at most one flag is reported.
  assign w_mis     = !w_ill && w_mis_raw;
  assign w_fault   = w_ill || w_mis_raw;

  // Upper address bits only matter for the range check on the live request.
  assign w_unused_addr = ^r_req.addr[31:DM_ADDRESS];

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_funct3 (r_req.funct3),
    .i_offset (r_req.addr[1:0]),
    .i_wdata  (r_req.wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata_rep),
    .o_rdata  (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fault ? RESP : ISSUE;
      ISSUE:   w_next = r_req.we ? RESP : RD_WAIT;
      RD_WAIT: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_re          = 1'b0;
    mem_we          = 4'b0000;
    mem_addr        = '0;
    mem_wdata       = '0;
    resp_valid      = 1'b0;
    resp_misaligned = 1'b0;
    resp_illegal    = 1'b0;
    if (r_state == ISSUE) begin
      mem_addr = {r_req.addr[DM_ADDRESS-1:2], 2'b00};
      if (r_req.we) begin
        mem_we    = w_be;
        mem_wdata = w_wdata_rep;
      end else begin
        mem_re    = 1'b1;
      end
    end
    if (r_state == RESP) begin
      resp_valid      = 1'b1;
      resp_misaligned = r_mis;
      resp_illegal    = r_ill;
    end
  end

  assign resp_rdata = r_rdata;

  // Fault flags and response data; rdata is loaded only on the RD_WAIT->RESP
  // step so it is nonzero for exactly the RESP cycle of a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis   <= 1'b0;
      r_ill   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_mis <= w_mis;
        r_ill <= w_ill;
      end
      r_rdata <= (r_state == RD_WAIT) ? w_ext : '0;
    end
  end

  // Request payload; only observed through ISSUE-qualified outputs.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req.we     <= req_we;
      r_req.funct3 <= req_funct3;
      r_req.addr   <= req_addr;
      r_req.wdata  <= req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_illegal    (resp_illegal),
    .mem_addr        (mem_addr),
    .mem_re          (mem_re),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents one request for a single accept cycle.
  // Returns in cycle T+1.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_before_req", 32'(req_ready), 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] want_addr,
                          input logic [31:0] want_be, input logic [31:0] want_wd);
    issue(1'b1, f3, a, wd);
    chk({tag, "_addr"}, 32'(mem_addr), want_addr);
    chk({tag, "_we"}, 32'(mem_we), want_be);
    chk({tag, "_wdata"}, mem_wdata, want_wd);
    chk({tag, "_re"}, 32'(mem_re), 32'h0);
    chk({tag, "_ready_busy"}, 32'(req_ready), 32'h0);
    step();
    chk({tag, "_resp"}, 32'(resp_valid), 32'h1);
    chk({tag, "_flags"}, 32'({resp_misaligned, resp_illegal}), 32'h0);
    chk({tag, "_we_off"}, 32'(mem_we), 32'h0);
    step();
    chk({tag, "_resp_off"}, 32'(resp_valid), 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] want_addr,
                         input logic [31:0] want);
    mem_rdata = rd;
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_re"}, 32'(mem_re), 32'h1);
    chk({tag, "_addr"}, 32'(mem_addr), want_addr);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    step();
    chk({tag, "_early"}, 32'(resp_valid), 32'h0);
    step();
    chk({tag, "_resp"}, 32'(resp_valid), 32'h1);
    chk({tag, "_rdata"}, resp_rdata, want);
    chk({tag, "_flags"}, 32'({resp_misaligned, resp_illegal}), 32'h0);
    step();
    chk({tag, "_rdata_clr"}, resp_rdata, 32'h0);
    chk({tag, "_ready_again"}, 32'(req_ready), 32'h1);
  endtask

  task automatic do_fault(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] want_mis,
                          input logic [31:0] want_ill);
    issue(we, f3, a, 32'h55AA55AA);
    chk({tag, "_resp"}, 32'(resp_valid), 32'h1);
    chk({tag, "_mis"}, 32'(resp_misaligned), want_mis);
    chk({tag, "_ill"}, 32'(resp_illegal), want_ill);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_mem"}, 32'({mem_re, mem_we}), 32'h0);
    step();
    chk({tag, "_resp_off"}, 32'(resp_valid), 32'h0);
    chk({tag, "_mem_after"}, 32'({mem_re, mem_we}), 32'h0);
  endtask

  // Back-to-back table: LBU 0x005, LH 0x006, SW 0x008 with req_valid held high.
  logic        b_we [3] = '{1'b0, 1'b0, 1'b1};
  logic [2:0]  b_f3 [3] = '{F3_BU, F3_H, F3_W};
  logic [31:0] b_ad [3] = '{32'h005, 32'h006, 32'h008};
  logic [31:0] b_wd [3] = '{32'h0, 32'h0, 32'h12345678};
  logic [31:0] b_rd [3] = '{32'h000000AA, 32'hFFFF8899, 32'h0};

  initial begin
    int          idx, nr;
    int          acc_c [3];
    int          resp_c [3];
    logic [31:0] resp_d [3];
    logic        acc_now;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp", 32'(resp_valid), 32'h0);
    chk("rst_mem", 32'({mem_re, mem_we}), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'h1);
    step();

    // Stores and loads
    do_store("sw", F3_W, 32'h010, 32'hDEADBEEF, 32'h010, 32'hF, 32'hDEADBEEF);
    do_store("sb", F3_B, 32'h013, 32'h000000A5, 32'h010, 32'h8, 32'hA5A5A5A5);
    do_load("lb", F3_B, 32'h013, 32'hA5000000, 32'h010, 32'hFFFFFFA5);
    do_load("lbu", F3_BU, 32'h013, 32'hA5000000, 32'h010, 32'h000000A5);
    do_store("sh", F3_H, 32'h012, 32'h00008001, 32'h010, 32'hC, 32'h80018001);
    do_load("lh", F3_H, 32'h012, 32'h80010000, 32'h010, 32'hFFFF8001);
    do_load("lhu", F3_HU, 32'h012, 32'h80010000, 32'h010, 32'h00008001);
    do_load("lw", F3_W, 32'h010, 32'hDEADBEEF, 32'h010, 32'hDEADBEEF);
    do_load("lb_top", F3_B, 32'h1FF, 32'h80000000, 32'h1FC, 32'hFFFFFF80);

    // Faults
    do_fault("lw_mis", 1'b0, F3_W, 32'h006, 32'h1, 32'h0);
    do_fault("sh_mis", 1'b1, F3_H, 32'h001, 32'h1, 32'h0);
    do_fault("lw_oor", 1'b0, F3_W, 32'h200, 32'h0, 32'h1);
    do_fault("st_f3", 1'b1, 3'b100, 32'h000, 32'h0, 32'h1);
    do_fault("ld_f3", 1'b0, 3'b011, 32'h000, 32'h0, 32'h1);
    do_fault("prio", 1'b0, F3_W, 32'h201, 32'h0, 32'h1);

    // Back-to-back load/load/store
    mem_rdata = 32'h8899AABB;
    idx = 0;
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      acc_c[i] = 0;
      resp_c[i] = 0;
      resp_d[i] = 32'h0;
    end
    req_valid  = 1'b1;
    req_we     = b_we[0];
    req_funct3 = b_f3[0];
    req_addr   = b_ad[0];
    req_wdata  = b_wd[0];
    for (int c = 0; c < 20; c++) begin
      if (resp_valid && nr < 3) begin
        resp_c[nr] = c;
        resp_d[nr] = resp_rdata;
        nr++;
      end
      acc_now = req_ready && (idx < 3);
      if (acc_now) acc_c[idx] = c;
      step();
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          req_we     = b_we[idx];
          req_funct3 = b_f3[idx];
          req_addr   = b_ad[idx];
          req_wdata  = b_wd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(idx), 32'd3);
    chk("b2b_resps", 32'(nr), 32'd3);
    chk("b2b_gap01", 32'(acc_c[1] - acc_c[0]), 32'd4);
    chk("b2b_gap12", 32'(acc_c[2] - acc_c[1]), 32'd4);
    chk("b2b_lat0", 32'(resp_c[0] - acc_c[0]), 32'd3);
    chk("b2b_lat1", 32'(resp_c[1] - acc_c[1]), 32'd3);
    chk("b2b_lat2", 32'(resp_c[2] - acc_c[2]), 32'd2);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_data%0d", i), resp_d[i], b_rd[i]);

    // Reset during the ISSUE cycle of a store
    step();
    issue(1'b1, F3_W, 32'h00C, 32'hCAFEF00D);
    chk("abort_we_before", 32'(mem_we), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("abort_we_now", 32'(mem_we), 32'h0);
    chk("abort_ready_low", 32'(req_ready), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("abort_ready_rel", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("abort_no_resp%0d", i), 32'(resp_valid), 32'h0);
      chk($sformatf("abort_no_we%0d", i), 32'(mem_we), 32'h0);
    end
    chk("abort_idle", 32'(req_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
